ofdm_demapper: RTL and testbench
================================

Name: ofdm_demapper

Overview:
- Receive-side counterpart of the OFDM symbol mapper. Makes hard decisions on signed I/Q samples, QPSK or 16-QAM, and recovers 2 or 4 bits per symbol.
- Packs the recovered bits LSB-first into a DATA_WIDTH word. Emits the word on a valid/ready handshake once num_bits bits are collected, or on flush.
- Sits between the equaliser output and the descrambler/bit sink.

Parameters:
DATA_WIDTH, 32, output word width; multiple of 4, at most 32
QAM_THRESH, 2, 16-QAM inner/outer decision threshold on |I|, |Q| (constellation levels ±1, ±3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
scheme_sel  in  2  00 = QPSK, 01 = 16-QAM, 10/11 = invalid
valid_in  in  1  I_in/Q_in valid
ready_out  out  1  block accepts a symbol this cycle
I_in  in  16  signed in-phase sample
Q_in  in  16  signed quadrature sample
num_bits  in  6  bits per output word (1..DATA_WIDTH; 0 means DATA_WIDTH)
flush  in  1  emit a partial word
data_out  out  DATA_WIDTH  packed bits, first symbol in the LSBs
bits_out  out  6  number of valid bits in data_out
valid_out  out  1  data_out/bits_out valid
ready_in  in  1  downstream accepts the word
sym_err  out  1  one-cycle pulse: a symbol was accepted with an invalid scheme

Behaviour:
- Reset (rst low, asynchronous):
  - state = ACCUM; accumulator and count cleared.
  - Outputs: data_out = 0, bits_out = 0, valid_out = 0, sym_err = 0, ready_out = 1 (ready_out is a state decode).
- States:
  - ACCUM: ready_out = 1, valid_out = 0.
  - OUTPUT: ready_out = 0, valid_out = 1.
- Accept: valid_in && ready_out. Symbols are accepted one per cycle.
- Word start: on the first accept with count == 0, latch scheme_sel and num_bits (0 → DATA_WIDTH). Later changes to either are ignored until the word is emitted.
- QPSK decision:
  - b0 = (I_in < 0), b1 = (Q_in < 0).
  - Zero decides as positive.
- 16-QAM decision:
  - b3 = (I_in >= 0), b2 = (-QAM_THRESH < I_in < QAM_THRESH).
  - b1 = (Q_in >= 0), b0 = (-QAM_THRESH < Q_in < QAM_THRESH).
  - |x| == QAM_THRESH decides as outer. -32768 decides as outer negative with no overflow; signed compares only, no abs().
- Packing: symbol bits {b(k-1)..b0} are written to acc[count +: k], then count += k. Bits above count are zero.
- Word completion:
  - Trigger: after an accept, if count >= latched num_bits, register the word.
  - Outputs: data_out = acc, bits_out = count, valid_out = 1 on the next clock; go to OUTPUT.
  - Latency: last accept at edge N → valid_out high after edge N.
  - A num_bits that is not a multiple of k rounds up; count never exceeds DATA_WIDTH.
- Invalid scheme (latched, or scheme_sel when count == 0): symbol is consumed, no bits are added, sym_err pulses for 1 cycle, state is unchanged.
- Flush:
  - flush in ACCUM with count > 0 → emit the partial word as above.
  - flush with count == 0 is ignored.
  - flush together with an accept: the symbol is included first, then the word is emitted.
  - flush in OUTPUT is ignored.
- OUTPUT:
  - data_out, bits_out and valid_out are held stable until ready_in.
  - On valid_out && ready_in: clear count and acc, return to ACCUM; valid_out = 0 and ready_out = 1 from the next cycle.
  - One bubble cycle per word.
  - valid_in is ignored while in OUTPUT.
- Reset mid-word or mid-OUTPUT: the partial word is discarded, no output is produced, and all outputs take their reset values.

Test Plan:
- QPSK, num_bits=8, symbols (23170,23170), (-23170,23170), (-23170,-23170), (23170,-23170), ready_in=1 -> data_out=0x000000B4, bits_out=8, valid_out high 1 cycle after the 4th accept, ready_out low for 1 cycle.
- 16-QAM, num_bits=8, symbols (3,-1), (-1,1) -> data_out=0x00000079, bits_out=8.
- 16-QAM boundaries, num_bits=8, symbols (0,2), (-2,-32768) -> nibbles 0xE then 0x0 -> data_out=0x0000000E.
- Backpressure: ready_in held low 5 cycles after a word, valid_in=1 throughout -> data_out/valid_out stable, ready_out=0, no symbols consumed; word handed off on the cycle ready_in rises.
- QPSK, num_bits=32, 3 symbols (-1,-1) then flush -> data_out=0x0000003F, bits_out=6. A later flush with count 0 -> no output.
- Invalid scheme 2'b10 on 2 accepts -> two sym_err pulses, no valid_out. Reset asserted after 2 of 4 QPSK symbols -> all outputs 0, ready_out=1, and the next 4-symbol word starts clean.

Source files
------------

// File: rtl/ofdm_demapper_if.sv
// ofdm_demapper_if: symbol-in / word-out handshake bundle for the OFDM demapper
interface ofdm_demapper_if #(parameter int DATA_WIDTH = 32);
  logic [1:0] scheme_sel;
  logic valid_in;
  logic ready_out;
  logic signed [15:0] I_in;
  logic signed [15:0] Q_in;
  logic [5:0] num_bits;
  logic flush;
  logic [DATA_WIDTH-1:0] data_out;
  logic [5:0] bits_out;
  logic valid_out;
  logic ready_in;
  logic sym_err;
  modport master (
    output scheme_sel, valid_in, I_in, Q_in, num_bits, flush, ready_in,
    input ready_out, data_out, bits_out, valid_out, sym_err
  );
  modport slave (
    input scheme_sel, valid_in, I_in, Q_in, num_bits, flush, ready_in,
    output ready_out, data_out, bits_out, valid_out, sym_err
  );
endinterface

// File: rtl/ofdm_demapper.sv
// ofdm_demapper: hard-decision QPSK/16-QAM demapper packing bits LSB-first into words
module ofdm_demapper #(
  parameter int DATA_WIDTH = 32,
  parameter int QAM_THRESH = 2
) (
  input logic clk,
  input logic rst,
  ofdm_demapper_if.slave bus
);
  typedef enum logic {ACCUM, OUTPUT} state_t;
  localparam logic signed [15:0] TH = 16'(QAM_THRESH);
  localparam logic [5:0] DW = 6'(DATA_WIDTH);
  state_t state;
  logic [DATA_WIDTH-1:0] acc, acc_n, data_q;
  logic [5:0] cnt, cnt_n, nb, nb_q, bits_q, k;
  logic [1:0] sch, sch_q;
  logic [3:0] sym;
  logic accept, qam, ok, emit, valid_q, err_q;
  // Decide the incoming symbol against the word's scheme and work out the packed next state
  always_comb begin
    accept = bus.valid_in && state == ACCUM;
    sch = cnt == 6'd0 ? bus.scheme_sel : sch_q;
    nb = cnt != 6'd0 ? nb_q : (bus.num_bits == 6'd0 || bus.num_bits > DW) ? DW : bus.num_bits;
    qam = sch == 2'b01;
    ok = !sch[1];
    k = qam ? 6'd4 : 6'd2;
    sym = qam ? {bus.I_in >= 16'sd0, bus.I_in > -TH && bus.I_in < TH,
                 bus.Q_in >= 16'sd0, bus.Q_in > -TH && bus.Q_in < TH}
              : {2'b00, bus.Q_in < 16'sd0, bus.I_in < 16'sd0};
    acc_n = accept && ok ? acc | (DATA_WIDTH'(sym) << cnt) : acc;
    cnt_n = accept && ok ? cnt + k : cnt;
    emit = cnt_n != 6'd0 && (bus.flush || cnt_n >= nb);
  end
  // Accumulate symbols, emit a word when full or flushed, hold it until the sink takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACCUM;
      acc <= '0;
      cnt <= '0;
      nb_q <= DW;
      sch_q <= '0;
      data_q <= '0;
      bits_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else if (state == ACCUM) begin
      err_q <= accept && !ok;
      acc <= acc_n;
      cnt <= cnt_n;
      if (accept && cnt == 6'd0) begin
        sch_q <= bus.scheme_sel;
        nb_q <= nb;
      end
      if (emit) begin
        data_q <= acc_n;
        bits_q <= cnt_n;
        valid_q <= 1'b1;
        state <= OUTPUT;
      end
    end else begin
      err_q <= 1'b0;
      if (bus.ready_in) begin
        valid_q <= 1'b0;
        acc <= '0;
        cnt <= '0;
        state <= ACCUM;
      end
    end
  end
  assign bus.ready_out = state == ACCUM;
  assign bus.valid_out = valid_q;
  assign bus.data_out = data_q;
  assign bus.bits_out = bits_q;
  assign bus.sym_err = err_q;
endmodule

// File: tb/tb_ofdm_demapper.sv
// tb_ofdm_demapper: directed stimulus checked against a bit-queue model of the demapper
module tb_ofdm_demapper;
  localparam int TH = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  ofdm_demapper_if #(.DATA_WIDTH(32)) bus();
  ofdm_demapper #(.DATA_WIDTH(32), .QAM_THRESH(TH)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  bit m_q[$];
  int m_sch, m_nb, m_bits;
  bit m_out, m_err;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out = 0;
    m_err = 0;
    m_data = 0;
    m_bits = 0;
    m_sch = 0;
    m_nb = 32;
  endtask

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  // Model of one clock edge: bits are kept as a plain list, word value built from it
  task automatic model_edge();
    int iv, qv;
    m_err = 0;
    if (m_out) begin
      if (bus.ready_in) begin
        m_out = 0;
        m_q.delete();
      end
    end else begin
      if (bus.valid_in) begin
        if (m_q.size() == 0) begin
          m_sch = int'(bus.scheme_sel);
          m_nb = bus.num_bits == 6'd0 ? 32 : int'(bus.num_bits);
        end
        iv = bus.I_in;
        qv = bus.Q_in;
        if (m_sch == 0) begin
          m_q.push_back(iv < 0);
          m_q.push_back(qv < 0);
        end else if (m_sch == 1) begin
          m_q.push_back(iabs(qv) < TH);
          m_q.push_back(qv >= 0);
          m_q.push_back(iabs(iv) < TH);
          m_q.push_back(iv >= 0);
        end else m_err = 1;
      end
      if (m_q.size() > 0 && (bus.flush || (bus.valid_in && m_q.size() >= m_nb))) begin
        m_data = 0;
        for (int j = 0; j < m_q.size(); j++) m_data[j] = m_q[j];
        m_bits = m_q.size();
        m_out = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic sym(input int s, input int i, input int q);
    bus.scheme_sel = 2'(s);
    bus.I_in = 16'(i);
    bus.Q_in = 16'(q);
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("ready_out", 32'(bus.ready_out), 32'(!m_out));
    chk("valid_out", 32'(bus.valid_out), 32'(m_out));
    chk("sym_err", 32'(bus.sym_err), 32'(m_err));
    chk("data_out", bus.data_out, m_data);
    chk("bits_out", 32'(bus.bits_out), 32'(m_bits));
  end

  initial begin
    bus.scheme_sel = 2'b00;
    bus.valid_in = 1'b0;
    bus.I_in = '0;
    bus.Q_in = '0;
    bus.num_bits = 6'd8;
    bus.flush = 1'b0;
    bus.ready_in = 1'b1;
    model_reset();
    #3;
    chk("rst_ready", 32'(bus.ready_out), 32'd1);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_data", bus.data_out, 32'd0);
    #9 rst = 1'b1;
    sym(0, 23170, 23170);
    sym(0, -23170, 23170);
    sym(0, -23170, -23170);
    sym(0, 23170, -23170);
    chk("qpsk_data", bus.data_out, 32'h000000B4);
    chk("qpsk_bits", 32'(bus.bits_out), 32'd8);
    chk("qpsk_valid", 32'(bus.valid_out), 32'd1);
    chk("qpsk_ready_low", 32'(bus.ready_out), 32'd0);
    step();
    chk("qpsk_ready_back", 32'(bus.ready_out), 32'd1);
    chk("qpsk_valid_drop", 32'(bus.valid_out), 32'd0);
    sym(1, 3, -1);
    sym(1, -1, 1);
    chk("qam_data", bus.data_out, 32'h00000079);
    chk("qam_bits", 32'(bus.bits_out), 32'd8);
    step();
    sym(1, 0, 2);
    sym(1, -2, -32768);
    chk("qam_edge_data", bus.data_out, 32'h0000000E);
    step();
    bus.num_bits = 6'd6;
    sym(1, 3, -1);
    chk("round_not_yet", 32'(bus.valid_out), 32'd0);
    sym(1, -1, 1);
    chk("round_data", bus.data_out, 32'h00000079);
    chk("round_bits", 32'(bus.bits_out), 32'd8);
    step();
    bus.num_bits = 6'd8;
    bus.ready_in = 1'b0;
    sym(0, 1, 1);
    sym(0, -1, 1);
    sym(0, 1, -1);
    sym(0, -1, -1);
    chk("bp_data", bus.data_out, 32'h000000E4);
    repeat (5) sym(0, -5, -5);
    chk("bp_hold_data", bus.data_out, 32'h000000E4);
    chk("bp_hold_valid", 32'(bus.valid_out), 32'd1);
    chk("bp_hold_ready", 32'(bus.ready_out), 32'd0);
    bus.ready_in = 1'b1;
    sym(0, -5, -5);
    chk("bp_release_valid", 32'(bus.valid_out), 32'd0);
    chk("bp_release_ready", 32'(bus.ready_out), 32'd1);
    step();
    bus.num_bits = 6'd32;
    sym(0, -1, -1);
    sym(0, -1, -1);
    sym(0, -1, -1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_data", bus.data_out, 32'h0000003F);
    chk("flush_bits", 32'(bus.bits_out), 32'd6);
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_empty", 32'(bus.valid_out), 32'd0);
    bus.num_bits = 6'd8;
    bus.flush = 1'b1;
    sym(0, -1, 1);
    bus.flush = 1'b0;
    chk("flush_accept_data", bus.data_out, 32'h00000001);
    chk("flush_accept_bits", 32'(bus.bits_out), 32'd2);
    step();
    bus.num_bits = 6'd0;
    repeat (7) sym(1, 3, 3);
    chk("full_not_yet", 32'(bus.valid_out), 32'd0);
    sym(1, 3, 3);
    chk("full_data", bus.data_out, 32'hAAAAAAAA);
    chk("full_bits", 32'(bus.bits_out), 32'd32);
    step();
    bus.num_bits = 6'd8;
    sym(2, 1, 1);
    chk("inv_err1", 32'(bus.sym_err), 32'd1);
    sym(3, 1, 1);
    chk("inv_err2", 32'(bus.sym_err), 32'd1);
    chk("inv_no_valid", 32'(bus.valid_out), 32'd0);
    step();
    chk("inv_err_clear", 32'(bus.sym_err), 32'd0);
    sym(0, -1, -1);
    sym(0, -1, -1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_data", bus.data_out, 32'd0);
    chk("midrst_bits", 32'(bus.bits_out), 32'd0);
    chk("midrst_ready", 32'(bus.ready_out), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    sym(0, 23170, 23170);
    sym(0, -23170, 23170);
    sym(0, -23170, -23170);
    sym(0, 23170, -23170);
    chk("clean_data", bus.data_out, 32'h000000B4);
    chk("clean_bits", 32'(bus.bits_out), 32'd8);
    step();
    bus.ready_in = 1'b0;
    repeat (4) sym(0, 1, 1);
    chk("outrst_valid_before", 32'(bus.valid_out), 32'd1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("outrst_valid", 32'(bus.valid_out), 32'd0);
    chk("outrst_ready", 32'(bus.ready_out), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    bus.ready_in = 1'b1;
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
